// File: rtl/a2d_conv_sched_pkg.sv
// Shared types and helpers for the A2D conversion scheduler.
package a2d_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, GAP, READ} state_t;
    typedef enum logic [1:0] {LFT, RGHT, STEER, BATT} chan_t;

    localparam logic [15:0] READ_CMD = 16'h0000;

    function automatic logic [15:0] build_cmd(input logic [2:0] addr);
        return {2'b00, addr, 11'h000};
    endfunction

    function automatic chan_t next_chan(input chan_t c);
        return chan_t'(c + 2'd1);
    endfunction

    // Sum at 13 bits so the carry survives before halving.
    function automatic logic [11:0] avg12(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[12:1];
    endfunction

endpackage

// File: rtl/a2d_conv_sched_if.sv
// SPI master handshake as seen by the conversion scheduler.
interface a2d_conv_sched_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/a2d_conv_sched_wdog.sv
// Per-transaction timeout counter; expired flags the last allowed wait cycle.
module a2d_wdog #(
    parameter int TMO_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + W'(1);
    end

    assign expired = en && (cnt == W'(TMO_CYC - 1));
endmodule

// File: rtl/a2d_conv_sched.sv
// Round-robin A2D conversion scheduler driving the SPI master (address, then read).
// Optional A2D_LOAD_AVG_EN: load cell results become a running two-sample average.
module a2d_conv_sched
    import a2d_pkg::*;
#(
    parameter int         TMO_CYC  = 1024,
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nxt,
    a2d_conv_sched_if.master   spi,
    output logic [11:0]        lft_ld,
    output logic [11:0]        rght_ld,
    output logic [11:0]        steer_pot,
    output logic [11:0]        batt,
    output logic [3:0]         upd,
    output logic               busy,
    output logic               tmo_err
);
    // state | meaning
    // IDLE  | waiting for nxt; ptr selects the channel to convert
    // ADDR  | address transaction in flight, waiting for done
    // GAP   | one cycle: issue the read transaction
    // READ  | read transaction in flight, result stored on done

    state_t      state;
    chan_t       ptr;
    logic        wrt_r;
    logic [15:0] cmd_r;
    logic [2:0]  addr;
    logic [11:0] sample;
    logic        issue;
    logic        wd_en;
    logic        expired;
    logic        unused_rd_hi;

`ifdef A2D_LOAD_AVG_EN
    logic        lft_seen;
    logic        rght_seen;
`endif

    assign sample       = spi.rd_data[11:0];
    assign unused_rd_hi = ^spi.rd_data[15:12];
    assign spi.wrt      = wrt_r;
    assign spi.cmd      = cmd_r;
    assign issue        = ((state == IDLE) && nxt) || (state == GAP);
    assign wd_en        = (state == ADDR) || (state == READ);

    always_comb begin
        addr = CH_LFT;
        case (ptr)
            RGHT:    addr = CH_RGHT;
            STEER:   addr = CH_STEER;
            BATT:    addr = CH_BATT;
            default: addr = CH_LFT;
        endcase
    end

    a2d_wdog #(.TMO_CYC(TMO_CYC)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (issue),
        .en      (wd_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= LFT;
            wrt_r     <= 1'b0;
            cmd_r     <= 16'h0000;
            busy      <= 1'b0;
            upd       <= 4'b0000;
            tmo_err   <= 1'b0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
`ifdef A2D_LOAD_AVG_EN
            lft_seen  <= 1'b0;
            rght_seen <= 1'b0;
`endif
        end else begin
            wrt_r   <= 1'b0;
            upd     <= 4'b0000;
            tmo_err <= 1'b0;
            case (state)
                IDLE: if (nxt) begin
                    wrt_r <= 1'b1;
                    cmd_r <= build_cmd(addr);
                    busy  <= 1'b1;
                    state <= ADDR;
                end
                ADDR: if (spi.done) begin
                    state <= GAP;
                end else if (expired) begin
                    tmo_err <= 1'b1;
                    busy    <= 1'b0;
                    ptr     <= next_chan(ptr);
                    state   <= IDLE;
                end
                GAP: begin
                    wrt_r <= 1'b1;
                    cmd_r <= READ_CMD;
                    state <= READ;
                end
                READ: if (spi.done) begin
                    case (ptr)
`ifdef A2D_LOAD_AVG_EN
                        LFT: begin
                            lft_ld   <= lft_seen ? avg12(lft_ld, sample) : sample;
                            lft_seen <= 1'b1;
                        end
                        RGHT: begin
                            rght_ld   <= rght_seen ? avg12(rght_ld, sample) : sample;
                            rght_seen <= 1'b1;
                        end
`else
                        LFT:  lft_ld  <= sample;
                        RGHT: rght_ld <= sample;
`endif
                        STEER:   steer_pot <= sample;
                        default: batt      <= sample;
                    endcase
                    upd   <= 4'b0001 << ptr;
                    ptr   <= next_chan(ptr);
                    busy  <= 1'b0;
                    state <= IDLE;
                end else if (expired) begin
                    tmo_err <= 1'b1;
                    busy    <= 1'b0;
                    ptr     <= next_chan(ptr);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_a2d_conv_sched.sv
// Randomized bench for a2d_conv_sched against an array-based model of the result registers.
module tb_a2d_conv_sched;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic [3:0]  upd;
    logic        busy, tmo_err;

    a2d_conv_sched_if spi ();

    a2d_conv_sched #(.TMO_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .nxt       (nxt),
        .spi       (spi),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .upd       (upd),
        .busy      (busy),
        .tmo_err   (tmo_err)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_wrt = 0;
    int exp_wrt = 0;
    int n_b2b = 0;
    logic prev_wrt = 1'b0;

    // model state: next channel and the four held results
    int ptr_m;
    int res_m [4];
    bit seen_m [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (spi.wrt) begin
            n_wrt++;
            if (prev_wrt) n_b2b++;
        end
        prev_wrt = spi.wrt;
    end

    function automatic int addr_of(input int p);
        case (p)
            0: return 0;
            1: return 4;
            2: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic logic [31:0] res_of(input int i);
        case (i)
            0: return {20'h0, lft_ld};
            1: return {20'h0, rght_ld};
            2: return {20'h0, steer_pot};
            default: return {20'h0, batt};
        endcase
    endfunction

    task automatic model_reset();
        ptr_m = 0;
        for (int i = 0; i < 4; i++) begin
            res_m[i] = 0;
            seen_m[i] = 0;
        end
    endtask

    task automatic model_store(input int data);
`ifdef A2D_LOAD_AVG_EN
        if (ptr_m < 2 && seen_m[ptr_m]) res_m[ptr_m] = (res_m[ptr_m] + data) / 2;
        else res_m[ptr_m] = data;
`else
        res_m[ptr_m] = data;
`endif
        seen_m[ptr_m] = 1;
        ptr_m = (ptr_m + 1) % 4;
    endtask

    task automatic chk_results(input string tag);
        for (int i = 0; i < 4; i++) chk(tag, res_of(i), res_m[i]);
    endtask

    task automatic wait_tmo();
        int k;
        k = 0;
        while (!tmo_err && k < 3 * TMO) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_latency", k, TMO);
        chk("tmo_busy", busy, 0);
        ptr_m = (ptr_m + 1) % 4;
        chk_results("tmo_results");
        @(negedge clk);
        chk("tmo_pulse", tmo_err, 0);
    endtask

    // hang: 0 normal, 1 withhold done on address, 2 withhold done on read
    task automatic convert(input logic [11:0] data, input int hang);
        logic [15:0] exp_cmd;
        exp_cmd = {2'b00, 3'(addr_of(ptr_m)), 11'h000};
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        chk("wrt_addr", spi.wrt, 1);
        chk("cmd_addr", spi.cmd, exp_cmd);
        chk("busy_set", busy, 1);
        exp_wrt++;
        if (hang == 1) begin
            wait_tmo();
            return;
        end
        repeat ($urandom_range(0, 4)) begin
            nxt = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        nxt = 1'($urandom_range(0, 1));
        spi.done = 1'b1;
        spi.rd_data = 16'($urandom);
        @(negedge clk);
        spi.done = 1'b0;
        nxt = 1'b0;
        chk("gap_no_wrt", spi.wrt, 0);
        @(negedge clk);
        chk("wrt_read", spi.wrt, 1);
        chk("cmd_read", spi.cmd, 16'h0000);
        exp_wrt++;
        if (hang == 2) begin
            wait_tmo();
            return;
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
        chk("cmd_hold", spi.cmd, 16'h0000);
        spi.done = 1'b1;
        spi.rd_data = {4'($urandom), data};
        nxt = 1'b1;
        @(negedge clk);
        spi.done = 1'b0;
        nxt = 1'b0;
        chk("upd_onehot", upd, 32'(1) << ptr_m);
        model_store(int'(data));
        chk_results("results");
        chk("busy_clr", busy, 0);
        @(negedge clk);
        chk("nxt_fall_ignored", spi.wrt, 0);
        chk("upd_pulse", upd, 0);
    endtask

    initial begin
        logic [11:0] full_vals [4];
        full_vals = '{12'hABC, 12'h123, 12'hFFF, 12'h800};
        spi.done = 1'b0;
        spi.rd_data = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_wrt", spi.wrt, 0);
        chk("rst_cmd", spi.cmd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd", upd, 0);
        chk("rst_tmo", tmo_err, 0);
        chk_results("rst_results");
        rst = 1'b0;
        @(negedge clk);

        // reset during a READ transaction, then a late done
        convert(12'h111, 0);
        convert(12'h222, 0);
        nxt = 1'b1; @(negedge clk); nxt = 1'b0;
        spi.done = 1'b1; @(negedge clk); spi.done = 1'b0;
        @(negedge clk);
        chk("pre_rst_read_wrt", spi.wrt, 1);
        exp_wrt += 2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        spi.done = 1'b1; spi.rd_data = 16'h0555;
        @(negedge clk);
        spi.done = 1'b0;
        model_reset();
        chk("midrst_busy", busy, 0);
        chk("midrst_upd", upd, 0);
        chk_results("midrst_results");
        @(negedge clk);

        // full round with fixed data
        for (int i = 0; i < 4; i++) convert(full_vals[i], 0);
        chk("round_lft", lft_ld, 12'hABC);
        chk("round_rght", rght_ld, 12'h123);
        chk("round_steer", steer_pot, 12'hFFF);
        chk("round_batt", batt, 12'h800);

        // stray done in IDLE
        spi.done = 1'b1; spi.rd_data = 16'h0777;
        @(negedge clk);
        spi.done = 1'b0;
        chk("stray_upd", upd, 0);
        chk("stray_busy", busy, 0);
        @(negedge clk);
        chk("stray_wrt", spi.wrt, 0);
        chk_results("stray_results");

        // timeout on the right load address transaction
        convert(12'h345, 0);
        convert(12'h000, 1);
        chk("tmo_rght_kept", rght_ld, 12'h123);
        chk("tmo_next_ptr", ptr_m, 2);
        convert(12'h456, 0);

        // averaging feature check on the left load
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        model_reset();
        @(negedge clk);
        convert(12'h400, 0);
        chk("avg_first", lft_ld, 12'h400);
        convert(12'h010, 0);
        convert(12'h020, 0);
        convert(12'h030, 0);
        convert(12'h600, 0);
`ifdef A2D_LOAD_AVG_EN
        chk("avg_second", lft_ld, 12'h500);
`else
        chk("avg_second", lft_ld, 12'h600);
`endif

        // randomized conversions with occasional timeouts
        for (int i = 0; i < 24; i++) begin
            int r;
            int hang;
            r = int'($urandom_range(0, 15));
            hang = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            convert(12'($urandom), hang);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("wrt_total", n_wrt, exp_wrt);
        chk("wrt_back_to_back", n_b2b, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
